cu_select_arbiter: RTL and testbench
====================================

Name: cu_select_arbiter

Overview:
- Downstream consumer of the per-resource CAM allocators in the CTA scheduler.
- Accepts one workgroup allocation request and broadcasts search enable plus sizes to the four resource CAMs: VGPR, SGPR, LDS and wavefront slots.
- Combines the four returned per-CU fit masks and picks one CU round-robin.
- Returns the chosen CU, or a fail indication, to the allocation controller over a valid/ready handshake.

Parameters:
- VGPR_ID_WIDTH, 10, VGPR resource id width; search size is VGPR_ID_WIDTH+1 bits.
- SGPR_ID_WIDTH, 10, SGPR resource id width; search size is SGPR_ID_WIDTH+1 bits.
- LDS_ID_WIDTH, 10, LDS resource id width; search size is LDS_ID_WIDTH+1 bits.
- WF_ID_WIDTH, 5, wavefront-slot id width; search size is WF_ID_WIDTH+1 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid_i  in  1  allocation request valid
- req_ready_o  out  1  block can accept a request
- req_vgpr_size_i  in  VGPR_ID_WIDTH+1  VGPRs needed
- req_sgpr_size_i  in  SGPR_ID_WIDTH+1  SGPRs needed
- req_lds_size_i  in  LDS_ID_WIDTH+1  LDS needed
- req_wf_size_i  in  WF_ID_WIDTH+1  wavefront slots needed
- res_search_en_o  out  1  search strobe to all four CAMs
- vgpr_search_size_o  out  VGPR_ID_WIDTH+1  to VGPR CAM
- sgpr_search_size_o  out  SGPR_ID_WIDTH+1  to SGPR CAM
- lds_search_size_o  out  LDS_ID_WIDTH+1  to LDS CAM
- wf_search_size_o  out  WF_ID_WIDTH+1  to WF CAM
- vgpr_search_out_i  in  `NUMBER_CU  VGPR CAM fit mask
- sgpr_search_out_i  in  `NUMBER_CU  SGPR CAM fit mask
- lds_search_out_i  in  `NUMBER_CU  LDS CAM fit mask
- wf_search_out_i  in  `NUMBER_CU  WF CAM fit mask
- cu_enable_i  in  `NUMBER_CU  static per-CU enable mask
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  result accepted
- rsp_fail_o  out  1  1 = no CU fits
- rsp_cu_id_o  out  `CU_ID_WIDTH  chosen CU; 0 when fail

Clock and reset: one clock (clk); reset rst_n is asynchronous, active-low.

Behaviour:
- Reset values: req_ready_o=0 (state leaves reset into IDLE, so req_ready_o is 1 from the first cycle after rst_n deasserts). res_search_en_o=0, all search sizes=0, rsp_valid_o=0, rsp_fail_o=0, rsp_cu_id_o=0, round-robin pointer=0, state=IDLE.
- FSM is IDLE -> SEARCH -> CHECK -> RESP -> IDLE.
- IDLE: req_ready_o=1. On req_valid_i & req_ready_o, register the four sizes into the search size outputs and go to SEARCH.
- SEARCH (exactly one cycle): res_search_en_o=1, sizes held. The CAMs register the enable and size on this edge, so their masks are valid during the following cycle. Go to CHECK.
- CHECK (one cycle): search sizes stay held and res_search_en_o=0.
  - cand = vgpr & sgpr & lds & wf masks & cu_enable_i, sampled this cycle.
  - If cand==0: register rsp_fail_o=1, rsp_cu_id_o=0.
  - Else: rsp_cu_id_o = first set bit of cand at or above the pointer, wrapping modulo `NUMBER_CU; rsp_fail_o=0.
  - Set rsp_valid_o=1 and go to RESP.
- RESP: hold rsp_valid_o, rsp_fail_o and rsp_cu_id_o stable until rsp_ready_i. On rsp_valid_o & rsp_ready_i: clear rsp_valid_o and go to IDLE.
  - On success, pointer <= (cu_id+1) mod `NUMBER_CU; this holds for non-power-of-two CU counts.
  - On fail, pointer is unchanged.
- Request-to-response latency: 3 cycles (accept edge, SEARCH, CHECK). rsp_valid_o rises on the edge that leaves CHECK.
- Only one request is in flight; req_ready_o=0 outside IDLE.
- A CAM write that coincides with CHECK is reflected in the masks seen that cycle; no further filtering is done.
- Changes to cu_enable_i are sampled only in CHECK.
- Zero-size requests pass through unchanged; every valid CAM entry matches.
- Asynchronous reset mid-operation returns to IDLE, drops rsp_valid_o and res_search_en_o, and clears the pointer.

Decomposition:
- Shared package / define.v: `NUMBER_CU, `CU_ID_WIDTH, and the state encoding localparams (IDLE=0, SEARCH=1, CHECK=2, RESP=3).
- One sub-module, rr_priority_picker: combinational. Inputs are the request mask and the pointer; outputs are grant_valid and the grant index. Implement as a double-width mask-and-find-first.

Test Plan:
- Reset, then request sizes 4/2/8/1 with all masks 0xF (4 CUs), rsp_ready_i=1 -> res_search_en_o high exactly one cycle after the accept edge; rsp_valid_o at +3 cycles with cu_id=0, fail=0; pointer becomes 1.
- Three back-to-back requests with all masks all-ones -> cu_id sequence 1, 2, 3, then 0 on a fourth request (wrap).
- Masks vgpr=0b1010, lds=0b0110, others all-ones, pointer=3 -> cu_id=1.
- Any one mask =0 -> rsp_fail_o=1, cu_id=0; next all-ones request returns the same CU as before the fail (pointer unchanged).
- rsp_ready_i held low 5 cycles -> rsp_valid_o, rsp_fail_o and rsp_cu_id_o stable; req_ready_o=0; accepted on the 6th cycle; IDLE on the next cycle.
- Assert rst_n low during CHECK -> rsp_valid_o=0 and res_search_en_o=0 immediately; after release, req_ready_o=1 and the next grant is cu_id=0.

Source files
------------

// File: rtl/cu_select_arbiter_pkg.sv
// Shared constants, state encoding and pointer helper for the CU select arbiter.
// The CU count is fixed here so every file agrees on mask and id widths.
package cu_select_arbiter_pkg;

    localparam int NUMBER_CU   = 4;
    localparam int CU_ID_WIDTH = (NUMBER_CU > 1) ? $clog2(NUMBER_CU) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_CHECK  = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    // Explicit wrap so CU counts that are not a power of two still cycle correctly.
    function automatic logic [CU_ID_WIDTH-1:0] next_ptr(input logic [CU_ID_WIDTH-1:0] cu);
        if (int'(cu) == NUMBER_CU - 1) return '0;
        else                           return cu + 1'b1;
    endfunction

endpackage

// File: rtl/cu_select_arbiter_if.sv
// Request/response channel between the allocation controller (master) and the
// CU select arbiter (slave). Signal names keep the arbiter's point of view.
interface cu_select_arbiter_if
    import cu_select_arbiter_pkg::*;
#(
    parameter int VGPR_ID_WIDTH = 10,
    parameter int SGPR_ID_WIDTH = 10,
    parameter int LDS_ID_WIDTH  = 10,
    parameter int WF_ID_WIDTH   = 5
);

    logic                     req_valid_i;
    logic                     req_ready_o;
    logic [VGPR_ID_WIDTH:0]   req_vgpr_size_i;
    logic [SGPR_ID_WIDTH:0]   req_sgpr_size_i;
    logic [LDS_ID_WIDTH:0]    req_lds_size_i;
    logic [WF_ID_WIDTH:0]     req_wf_size_i;

    logic                     rsp_valid_o;
    logic                     rsp_ready_i;
    logic                     rsp_fail_o;
    logic [CU_ID_WIDTH-1:0]   rsp_cu_id_o;

    modport master (
        output req_valid_i, req_vgpr_size_i, req_sgpr_size_i, req_lds_size_i,
               req_wf_size_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_fail_o, rsp_cu_id_o
    );

    modport slave (
        input  req_valid_i, req_vgpr_size_i, req_sgpr_size_i, req_lds_size_i,
               req_wf_size_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_fail_o, rsp_cu_id_o
    );

endinterface

// File: rtl/cu_select_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: lowest set request bit at or above the
// pointer, wrapping, found by masking a doubled copy of the request vector.
module rr_priority_picker
    import cu_select_arbiter_pkg::*;
#(
    parameter int N     = NUMBER_CU,
    parameter int IDX_W = CU_ID_WIDTH
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             grant_valid_o,
    output logic [IDX_W-1:0] grant_o
);

    localparam int DW     = 2 * N;
    localparam int DW_IDX = $clog2(DW);

    logic [DW-1:0]     dbl;
    logic [DW-1:0]     masked;
    logic [DW_IDX-1:0] first;

    // NOTE: every output gets a default before any conditional write so no latch is inferred.
    always_comb begin
        grant_valid_o = |req_i;
        grant_o       = '0;
        first         = '0;
        // The upper copy guarantees a hit below the pointer when the lower copy has none.
        dbl    = {req_i, req_i};
        masked = dbl & ({DW{1'b1}} << ptr_i);
        for (int i = DW - 1; i >= 0; i--) begin
            if (masked[i]) first = DW_IDX'(i);
        end
        if (int'(first) >= N) grant_o = IDX_W'(int'(first) - N);
        else                  grant_o = IDX_W'(first);
    end

endmodule

// File: rtl/cu_select_arbiter.sv
// Broadcasts a workgroup's resource sizes to the four CAMs, intersects their
// fit masks with the CU enable mask and returns one CU chosen round-robin.
module cu_select_arbiter
    import cu_select_arbiter_pkg::*;
#(
    parameter int VGPR_ID_WIDTH = 10,
    parameter int SGPR_ID_WIDTH = 10,
    parameter int LDS_ID_WIDTH  = 10,
    parameter int WF_ID_WIDTH   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    cu_select_arbiter_if.slave      alloc,

    output logic                    res_search_en_o,
    output logic [VGPR_ID_WIDTH:0]  vgpr_search_size_o,
    output logic [SGPR_ID_WIDTH:0]  sgpr_search_size_o,
    output logic [LDS_ID_WIDTH:0]   lds_search_size_o,
    output logic [WF_ID_WIDTH:0]    wf_search_size_o,

    input  logic [NUMBER_CU-1:0]    vgpr_search_out_i,
    input  logic [NUMBER_CU-1:0]    sgpr_search_out_i,
    input  logic [NUMBER_CU-1:0]    lds_search_out_i,
    input  logic [NUMBER_CU-1:0]    wf_search_out_i,
    input  logic [NUMBER_CU-1:0]    cu_enable_i
);

    state_e                  state_q;
    logic                    req_ready_q;
    logic                    search_en_q;
    logic [VGPR_ID_WIDTH:0]  vgpr_size_q;
    logic [SGPR_ID_WIDTH:0]  sgpr_size_q;
    logic [LDS_ID_WIDTH:0]   lds_size_q;
    logic [WF_ID_WIDTH:0]    wf_size_q;
    logic                    rsp_valid_q;
    logic                    rsp_fail_q;
    logic [CU_ID_WIDTH-1:0]  rsp_cu_id_q;
    logic [CU_ID_WIDTH-1:0]  ptr_q;

    logic [NUMBER_CU-1:0]    cand;
    logic                    grant_valid;
    logic [CU_ID_WIDTH-1:0]  grant_idx;

    // Masks are only meaningful in CHECK; the FSM ignores cand in every other state.
    assign cand = vgpr_search_out_i & sgpr_search_out_i & lds_search_out_i
                & wf_search_out_i & cu_enable_i;

    rr_priority_picker #(
        .N     (NUMBER_CU),
        .IDX_W (CU_ID_WIDTH)
    ) u_picker (
        .req_i         (cand),
        .ptr_i         (ptr_q),
        .grant_valid_o (grant_valid),
        .grant_o       (grant_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            search_en_q <= 1'b0;
            vgpr_size_q <= '0;
            sgpr_size_q <= '0;
            lds_size_q  <= '0;
            wf_size_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_fail_q  <= 1'b0;
            rsp_cu_id_q <= '0;
            ptr_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (alloc.req_valid_i && req_ready_q) begin
                        vgpr_size_q <= alloc.req_vgpr_size_i;
                        sgpr_size_q <= alloc.req_sgpr_size_i;
                        lds_size_q  <= alloc.req_lds_size_i;
                        wf_size_q   <= alloc.req_wf_size_i;
                        req_ready_q <= 1'b0;
                        search_en_q <= 1'b1;
                        state_q     <= ST_SEARCH;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end

                // CAMs capture the strobe on this edge; their masks settle during CHECK.
                ST_SEARCH: begin
                    search_en_q <= 1'b0;
                    state_q     <= ST_CHECK;
                end

                ST_CHECK: begin
                    rsp_valid_q <= 1'b1;
                    if (grant_valid) begin
                        rsp_fail_q  <= 1'b0;
                        rsp_cu_id_q <= grant_idx;
                    end else begin
                        rsp_fail_q  <= 1'b1;
                        rsp_cu_id_q <= '0;
                    end
                    state_q <= ST_RESP;
                end

                ST_RESP: begin
                    if (alloc.rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        // A failed search leaves the pointer where it was.
                        if (!rsp_fail_q) ptr_q <= next_ptr(rsp_cu_id_q);
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign alloc.req_ready_o = req_ready_q;
    assign alloc.rsp_valid_o = rsp_valid_q;
    assign alloc.rsp_fail_o  = rsp_fail_q;
    assign alloc.rsp_cu_id_o = rsp_cu_id_q;

    assign res_search_en_o    = search_en_q;
    assign vgpr_search_size_o = vgpr_size_q;
    assign sgpr_search_size_o = sgpr_size_q;
    assign lds_search_size_o  = lds_size_q;
    assign wf_search_size_o   = wf_size_q;

endmodule

// File: tb/tb_cu_select_arbiter.sv
// Directed bench for cu_select_arbiter: latency, round-robin order, mask
// intersection, fail handling, response back-pressure and asynchronous reset.
module tb_cu_select_arbiter;
    import cu_select_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic                 res_search_en;
    logic [10:0]          vgpr_size, sgpr_size, lds_size;
    logic [5:0]           wf_size;
    logic [NUMBER_CU-1:0] vgpr_m, sgpr_m, lds_m, wf_m, cu_en;

    int tests_run    = 0;
    int tests_failed = 0;

    cu_select_arbiter_if bus ();

    cu_select_arbiter dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .alloc              (bus),
        .res_search_en_o    (res_search_en),
        .vgpr_search_size_o (vgpr_size),
        .sgpr_search_size_o (sgpr_size),
        .lds_search_size_o  (lds_size),
        .wf_search_size_o   (wf_size),
        .vgpr_search_out_i  (vgpr_m),
        .sgpr_search_out_i  (sgpr_m),
        .lds_search_out_i   (lds_m),
        .wf_search_out_i    (wf_m),
        .cu_enable_i        (cu_en)
    );

    always #5 clk = ~clk;

    // Drives one request and waits (bounded) for the response; with rsp_ready_i high
    // it also steps past the handshake edge so the arbiter is back in IDLE.
    task automatic do_request(input logic [10:0] v, input logic [10:0] s, input logic [10:0] l,
                              input logic [5:0] w, output logic [CU_ID_WIDTH-1:0] cu,
                              output logic fail, output bit timed_out);
        int n;
        timed_out = 1'b0;
        @(negedge clk);
        bus.req_valid_i     = 1'b1;
        bus.req_vgpr_size_i = v;
        bus.req_sgpr_size_i = s;
        bus.req_lds_size_i  = l;
        bus.req_wf_size_i   = w;
        n = 0;
        while (!bus.req_ready_o && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        n = 0;
        while (!bus.rsp_valid_o && n < 20) begin @(negedge clk); n++; end
        if (!bus.rsp_valid_o) timed_out = 1'b1;
        cu   = bus.rsp_cu_id_o;
        fail = bus.rsp_fail_o;
        if (bus.rsp_ready_i) @(negedge clk);
    endtask

    task automatic set_masks(input logic [3:0] v, input logic [3:0] s, input logic [3:0] l,
                             input logic [3:0] w, input logic [3:0] e);
        vgpr_m = v; sgpr_m = s; lds_m = l; wf_m = w; cu_en = e;
    endtask

    task automatic test_reset();
        #1;
        tests_run++;
        if (bus.req_ready_o !== 1'b0 || res_search_en !== 1'b0 || bus.rsp_valid_o !== 1'b0 ||
            bus.rsp_fail_o !== 1'b0 || bus.rsp_cu_id_o !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: ready=%b en=%b valid=%b fail=%b cu=%0d, expected all 0",
                     bus.req_ready_o, res_search_en, bus.rsp_valid_o, bus.rsp_fail_o, bus.rsp_cu_id_o);
        end
        tests_run++;
        if ({vgpr_size, sgpr_size, lds_size, wf_size} !== '0) begin
            tests_failed++;
            $display("FAIL reset_sizes: got %0d/%0d/%0d/%0d expected 0/0/0/0",
                     vgpr_size, sgpr_size, lds_size, wf_size);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus.req_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready_first: got %b expected 0", bus.req_ready_o);
        end
        @(negedge clk);
        tests_run++;
        if (bus.req_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready_idle: got %b expected 1", bus.req_ready_o);
        end
    endtask

    task automatic test_first_grant();
        set_masks(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        bus.req_valid_i     = 1'b1;
        bus.req_vgpr_size_i = 11'd4;
        bus.req_sgpr_size_i = 11'd2;
        bus.req_lds_size_i  = 11'd8;
        bus.req_wf_size_i   = 6'd1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        tests_run++;
        if (res_search_en !== 1'b1 || bus.req_ready_o !== 1'b0 || bus.rsp_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL first_search: en=%b ready=%b valid=%b expected 1/0/0",
                     res_search_en, bus.req_ready_o, bus.rsp_valid_o);
        end
        tests_run++;
        if (vgpr_size !== 11'd4 || sgpr_size !== 11'd2 || lds_size !== 11'd8 || wf_size !== 6'd1) begin
            tests_failed++;
            $display("FAIL first_sizes: got %0d/%0d/%0d/%0d expected 4/2/8/1",
                     vgpr_size, sgpr_size, lds_size, wf_size);
        end
        @(negedge clk);
        tests_run++;
        if (res_search_en !== 1'b0 || bus.rsp_valid_o !== 1'b0 || vgpr_size !== 11'd4 || wf_size !== 6'd1) begin
            tests_failed++;
            $display("FAIL first_check: en=%b valid=%b vgpr=%0d wf=%0d expected 0/0/4/1",
                     res_search_en, bus.rsp_valid_o, vgpr_size, wf_size);
        end
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid_o !== 1'b1 || bus.rsp_fail_o !== 1'b0 || bus.rsp_cu_id_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL first_resp: valid=%b fail=%b cu=%0d expected 1/0/0",
                     bus.rsp_valid_o, bus.rsp_fail_o, bus.rsp_cu_id_o);
        end
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL first_idle: valid=%b ready=%b expected 0/1", bus.rsp_valid_o, bus.req_ready_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [CU_ID_WIDTH-1:0] cu;
        logic fail;
        bit to;
        logic [CU_ID_WIDTH-1:0] exp_seq [4];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
        set_masks(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        for (int i = 0; i < 4; i++) begin
            do_request(11'd1, 11'd1, 11'd1, 6'd1, cu, fail, to);
            tests_run++;
            if (to || fail !== 1'b0 || cu !== exp_seq[i]) begin
                tests_failed++;
                $display("FAIL b2b_%0d: cu=%0d fail=%b timeout=%0d expected cu=%0d fail=0",
                         i, cu, fail, to, exp_seq[i]);
            end
        end
    endtask

    task automatic test_mask_combine();
        logic [CU_ID_WIDTH-1:0] cu;
        logic fail;
        bit to;
        set_masks(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        do_request(11'd1, 11'd1, 11'd1, 6'd1, cu, fail, to);
        do_request(11'd1, 11'd1, 11'd1, 6'd1, cu, fail, to);
        tests_run++;
        if (to || cu !== 2'd2) begin
            tests_failed++;
            $display("FAIL combine_setup: cu=%0d timeout=%0d expected 2", cu, to);
        end
        // Pointer now 3; only CU1 survives the intersection, so the search wraps.
        set_masks(4'b1010, 4'hF, 4'b0110, 4'hF, 4'hF);
        do_request(11'd0, 11'd0, 11'd0, 6'd0, cu, fail, to);
        tests_run++;
        if (to || fail !== 1'b0 || cu !== 2'd1) begin
            tests_failed++;
            $display("FAIL combine_wrap: cu=%0d fail=%b timeout=%0d expected cu=1 fail=0", cu, fail, to);
        end
    endtask

    task automatic test_fail();
        logic [CU_ID_WIDTH-1:0] cu;
        logic fail;
        bit to;
        set_masks(4'hF, 4'h0, 4'hF, 4'hF, 4'hF);
        do_request(11'd3, 11'd3, 11'd3, 6'd3, cu, fail, to);
        tests_run++;
        if (to || fail !== 1'b1 || cu !== 2'd0) begin
            tests_failed++;
            $display("FAIL fail_zero_mask: fail=%b cu=%0d timeout=%0d expected fail=1 cu=0", fail, cu, to);
        end
        // The only fitting CU is disabled.
        set_masks(4'hF, 4'hF, 4'hF, 4'b0001, 4'b1110);
        do_request(11'd3, 11'd3, 11'd3, 6'd3, cu, fail, to);
        tests_run++;
        if (to || fail !== 1'b1 || cu !== 2'd0) begin
            tests_failed++;
            $display("FAIL fail_disabled: fail=%b cu=%0d timeout=%0d expected fail=1 cu=0", fail, cu, to);
        end
        set_masks(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        do_request(11'd3, 11'd3, 11'd3, 6'd3, cu, fail, to);
        tests_run++;
        if (to || fail !== 1'b0 || cu !== 2'd2) begin
            tests_failed++;
            $display("FAIL fail_ptr_kept: cu=%0d fail=%b timeout=%0d expected cu=2 fail=0", cu, fail, to);
        end
    endtask

    task automatic test_backpressure();
        int n;
        set_masks(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        bus.rsp_ready_i = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        n = 0;
        while (!bus.rsp_valid_o && n < 20) begin @(negedge clk); n++; end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (bus.rsp_valid_o !== 1'b1 || bus.rsp_fail_o !== 1'b0 || bus.rsp_cu_id_o !== 2'd3 ||
                bus.req_ready_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold_%0d: valid=%b fail=%b cu=%0d ready=%b expected 1/0/3/0",
                         i, bus.rsp_valid_o, bus.rsp_fail_o, bus.rsp_cu_id_o, bus.req_ready_o);
            end
            @(negedge clk);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_release: valid=%b ready=%b expected 0/1", bus.rsp_valid_o, bus.req_ready_o);
        end
    endtask

    task automatic test_async_reset();
        logic [CU_ID_WIDTH-1:0] cu;
        logic fail;
        bit to;
        set_masks(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        // Pointer was wrapped to 0; move it to 1 so the reset clear is observable.
        do_request(11'd1, 11'd1, 11'd1, 6'd1, cu, fail, to);
        tests_run++;
        if (to || cu !== 2'd0) begin
            tests_failed++;
            $display("FAIL areset_setup: cu=%0d timeout=%0d expected 0", cu, to);
        end
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.rsp_valid_o !== 1'b0 || res_search_en !== 1'b0 || bus.req_ready_o !== 1'b0 || vgpr_size !== '0) begin
            tests_failed++;
            $display("FAIL areset_during: valid=%b en=%b ready=%b vgpr=%0d expected 0/0/0/0",
                     bus.rsp_valid_o, res_search_en, bus.req_ready_o, vgpr_size);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_ready: got %b expected 1", bus.req_ready_o);
        end
        do_request(11'd1, 11'd1, 11'd1, 6'd1, cu, fail, to);
        tests_run++;
        if (to || fail !== 1'b0 || cu !== 2'd0) begin
            tests_failed++;
            $display("FAIL areset_ptr: cu=%0d fail=%b timeout=%0d expected cu=0 fail=0", cu, fail, to);
        end
    endtask

    initial begin
        rst_n               = 1'b0;
        bus.req_valid_i     = 1'b0;
        bus.req_vgpr_size_i = '0;
        bus.req_sgpr_size_i = '0;
        bus.req_lds_size_i  = '0;
        bus.req_wf_size_i   = '0;
        bus.rsp_ready_i     = 1'b1;
        set_masks(4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
        @(negedge clk);
        test_reset();
        test_first_grant();
        test_back_to_back();
        test_mask_combine();
        test_fail();
        test_backpressure();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
